// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the 2-read/1-write register file: default geometry
// and the read-during-write ordering encodings.
package rf_pkg;

   localparam int RF_WIDTH  = 16;
   localparam int RF_DEPTH  = 8;
   localparam int RF_ADDR_W = 3;

   // Values for the BYPASS parameter.
   localparam int RF_WRITE_FIRST = 1;
   localparam int RF_READ_FIRST  = 0;

endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// One registered read port: resolves range, written flag and read-during-write
// ordering against the write port and clear, then registers the result.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int BYPASS = RF_WRITE_FIRST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [WIDTH-1:0]  mem [DEPTH],
   input  logic [DEPTH-1:0]  written,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata,
   output logic              rvalid,
   output logic              rmiss
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic             in_range;
   logic [WIDTH-1:0] rd_data;
   logic             rd_miss;

   assign in_range = ({1'b0, raddr} < DEPTH_L);

   always_comb begin
      rd_data = '0;
      rd_miss = 1'b1;
      if (in_range) begin
         // Write-first ordering sees this cycle's clear or write; read-first
         // always sees the array as it stood before the edge.
         if (BYPASS == RF_WRITE_FIRST && clr) begin
            rd_data = '0;
            rd_miss = 1'b1;
         end else if (BYPASS == RF_WRITE_FIRST && we && waddr == raddr) begin
            rd_data = wdata;
            rd_miss = 1'b0;
         end else begin
            rd_data = mem[raddr];
            rd_miss = ~written[raddr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
         rmiss  <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) begin
            rdata <= rd_data;
            rmiss <= rd_miss;
         end else begin
            rmiss <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH register file, one write port and two registered read ports,
// with per-entry written flags and out-of-range write reporting.
module reg_file_2r1w
   import rf_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int BYPASS = RF_WRITE_FIRST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re_a,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   output logic              rvalid_a,
   output logic              rmiss_a,
   input  logic              re_b,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b,
   output logic              rvalid_b,
   output logic              rmiss_b,
   output logic              werr
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written;
   logic             w_in_range;

   assign w_in_range = ({1'b0, waddr} < DEPTH_L);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         written <= '0;
         werr    <= 1'b0;
      end else begin
         // Out-of-range writes are reported even when clr drops the write.
         werr <= we && !w_in_range;
         if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            written <= '0;
         end else if (we && w_in_range) begin
            mem[waddr]     <= wdata;
            written[waddr] <= 1'b1;
         end
      end
   end

   rf_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
   ) u_port_a (
      .clk(clk), .reset(reset), .clr(clr),
      .we(we), .waddr(waddr), .wdata(wdata),
      .mem(mem), .written(written),
      .re(re_a), .raddr(raddr_a),
      .rdata(rdata_a), .rvalid(rvalid_a), .rmiss(rmiss_a)
   );

   rf_read_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
   ) u_port_b (
      .clk(clk), .reset(reset), .clr(clr),
      .we(we), .waddr(waddr), .wdata(wdata),
      .mem(mem), .written(written),
      .re(re_b), .raddr(raddr_b),
      .rdata(rdata_b), .rvalid(rvalid_b), .rmiss(rmiss_b)
   );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: read-first (index 0) and write-first (index 1)
// instances share one stimulus stream and are checked against a bench model.
module tb_reg_file_2r1w;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 6;
   localparam int ADDR_W = 3;

   logic              clk;
   logic              reset, clr, we, re_a, re_b;
   logic [ADDR_W-1:0] waddr, raddr_a, raddr_b;
   logic [WIDTH-1:0]  wdata;

   logic [WIDTH-1:0]  rdata_a [2];
   logic [WIDTH-1:0]  rdata_b [2];
   logic              rvalid_a [2];
   logic              rvalid_b [2];
   logic              rmiss_a [2];
   logic              rmiss_b [2];
   logic              werr [2];

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   for (genvar m = 0; m < 2; m++) begin : g_dut
      reg_file_2r1w #(
         .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(m)
      ) u_dut (
         .clk(clk), .reset(reset), .clr(clr),
         .we(we), .waddr(waddr), .wdata(wdata),
         .re_a(re_a), .raddr_a(raddr_a),
         .rdata_a(rdata_a[m]), .rvalid_a(rvalid_a[m]), .rmiss_a(rmiss_a[m]),
         .re_b(re_b), .raddr_b(raddr_b),
         .rdata_b(rdata_b[m]), .rvalid_b(rvalid_b[m]), .rmiss_b(rmiss_b[m]),
         .werr(werr[m])
      );
   end

   // ---------------- behavioural model ----------------
   int          mem_m [DEPTH];
   bit          wr_m [DEPTH];
   logic [15:0] e_rdata_a [2];
   logic [15:0] e_rdata_b [2];
   logic        e_rvalid_a [2];
   logic        e_rvalid_b [2];
   logic        e_rmiss_a [2];
   logic        e_rmiss_b [2];
   logic        e_werr [2];
   bit          model_ready = 0;

   function automatic void port_model(input int m, input logic re, input logic [2:0] a,
                                      inout logic [15:0] d, output logic v, output logic ms);
      v  = re;
      ms = 1'b0;
      if (re) begin
         if (int'(a) >= DEPTH) begin
            d = 0; ms = 1'b1;
         end else if (m == 1 && clr) begin
            d = 0; ms = 1'b1;
         end else if (m == 1 && we && waddr == a) begin
            d = wdata; ms = 1'b0;
         end else begin
            d = 16'(mem_m[a]); ms = !wr_m[a];
         end
      end
   endfunction

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            e_rdata_a[m] = 0; e_rvalid_a[m] = 0; e_rmiss_a[m] = 0;
            e_rdata_b[m] = 0; e_rvalid_b[m] = 0; e_rmiss_b[m] = 0;
            e_werr[m] = 0;
         end else begin
            port_model(m, re_a, raddr_a, e_rdata_a[m], e_rvalid_a[m], e_rmiss_a[m]);
            port_model(m, re_b, raddr_b, e_rdata_b[m], e_rvalid_b[m], e_rmiss_b[m]);
            e_werr[m] = we && (int'(waddr) >= DEPTH);
         end
      end
      if (reset || clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 0; wr_m[i] = 0;
         end
      end else if (we && int'(waddr) < DEPTH) begin
         mem_m[waddr] = int'(wdata);
         wr_m[waddr]  = 1;
      end
      model_ready = 1;
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (model_ready) begin
         for (int m = 0; m < 2; m++) begin
            check($sformatf("rdata_a[%0d]", m),  32'(rdata_a[m]),  32'(e_rdata_a[m]));
            check($sformatf("rvalid_a[%0d]", m), 32'(rvalid_a[m]), 32'(e_rvalid_a[m]));
            check($sformatf("rmiss_a[%0d]", m),  32'(rmiss_a[m]),  32'(e_rmiss_a[m]));
            check($sformatf("rdata_b[%0d]", m),  32'(rdata_b[m]),  32'(e_rdata_b[m]));
            check($sformatf("rvalid_b[%0d]", m), 32'(rvalid_b[m]), 32'(e_rvalid_b[m]));
            check($sformatf("rmiss_b[%0d]", m),  32'(rmiss_b[m]),  32'(e_rmiss_b[m]));
            check($sformatf("werr[%0d]", m),     32'(werr[m]),     32'(e_werr[m]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      clr = 0; we = 0; re_a = 0; re_b = 0;
   endtask

   task automatic write(input int a, input int d);
      idle();
      we = 1; waddr = 3'(a); wdata = 16'(d);
      tick();
      we = 0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1; clr = 0; we = 0; waddr = 0; wdata = 0;
      re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0;
      tick(); tick();
      check("reset_rvalid_a", 32'(rvalid_a[1]), 0);
      check("reset_rdata_a",  32'(rdata_a[1]), 0);
      check("reset_werr",     32'(werr[0]), 0);
      reset = 0;

      // Read of a never-written entry after reset
      re_a = 1; raddr_a = 0; tick();
      check("unwritten_rvalid", 32'(rvalid_a[1]), 1);
      check("unwritten_rdata",  32'(rdata_a[1]), 0);
      check("unwritten_rmiss",  32'(rmiss_a[1]), 1);

      // Write then read: one-cycle latency, single-cycle rvalid
      write(3, 34);
      re_a = 1; raddr_a = 3; tick();
      for (int m = 0; m < 2; m++) begin
         check("lat_rdata", 32'(rdata_a[m]), 34);
         check("lat_rmiss", 32'(rmiss_a[m]), 0);
         check("lat_rvalid", 32'(rvalid_a[m]), 1);
      end
      idle(); tick();
      check("lat_rvalid_drop", 32'(rvalid_a[1]), 0);
      check("lat_rdata_hold",  32'(rdata_a[1]), 34);

      // Read-during-write on both ports
      write(5, 12);
      we = 1; waddr = 5; wdata = 27;
      re_a = 1; raddr_a = 5; re_b = 1; raddr_b = 5;
      tick();
      check("rdw_wf_a", 32'(rdata_a[1]), 27);
      check("rdw_wf_b", 32'(rdata_b[1]), 27);
      check("rdw_rf_a", 32'(rdata_a[0]), 12);
      check("rdw_rf_b", 32'(rdata_b[0]), 12);
      we = 0; tick();
      check("rdw_after_wf", 32'(rdata_a[1]), 27);
      check("rdw_after_rf", 32'(rdata_b[0]), 27);

      // Dual port independence
      write(1, 51);
      write(2, 90);
      for (int i = 0; i < 4; i++) begin
         re_a = 1; raddr_a = 1; re_b = 1; raddr_b = 2;
         tick();
         check("dual_a", 32'(rdata_a[i % 2]), 51);
         check("dual_b", 32'(rdata_b[i % 2]), 90);
      end
      re_b = 0; tick();
      check("dual_b_rvalid_drop", 32'(rvalid_b[1]), 0);
      check("dual_b_hold",        32'(rdata_b[1]), 90);

      // Out-of-range write and read
      idle(); we = 1; waddr = 7; wdata = 1; tick();
      check("werr_pulse", 32'(werr[1]), 1);
      idle(); tick();
      check("werr_clear", 32'(werr[1]), 0);
      re_a = 1; raddr_a = 6; re_b = 1; raddr_b = 7; tick();
      check("oor_rdata_a", 32'(rdata_a[0]), 0);
      check("oor_rmiss_a", 32'(rmiss_a[0]), 1);
      check("oor_rmiss_b", 32'(rmiss_b[1]), 1);
      for (int i = 0; i < DEPTH; i++) begin
         re_a = 1; raddr_a = 3'(i); re_b = 0; tick();
      end

      // clr versus a write, with a same-cycle read
      for (int i = 0; i < 4; i++) write(i, 100 + i);
      idle(); clr = 1; we = 1; waddr = 0; wdata = 16; re_a = 1; raddr_a = 0; tick();
      check("clr_rd_wf_data", 32'(rdata_a[1]), 0);
      check("clr_rd_wf_miss", 32'(rmiss_a[1]), 1);
      check("clr_rd_rf_data", 32'(rdata_a[0]), 100);
      check("clr_rd_rf_miss", 32'(rmiss_a[0]), 0);
      idle(); clr = 1; we = 1; waddr = 7; tick();
      check("clr_werr", 32'(werr[0]), 1);
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         re_a = 1; raddr_a = 3'(i); re_b = 1; raddr_b = 3'(DEPTH - 1 - i);
         tick();
         check("post_clr_data", 32'(rdata_a[1]), 0);
         check("post_clr_miss", 32'(rmiss_a[0]), 1);
      end

      // Mixed traffic, model-checked every cycle
      for (int i = 0; i < 40; i++) begin
         clr = ($urandom_range(0, 15) == 0);
         we = 1'($urandom_range(0, 1));
         waddr = 3'($urandom_range(0, 7));
         wdata = 16'($urandom_range(0, 65535));
         re_a = 1'($urandom_range(0, 1));
         raddr_a = ($urandom_range(0, 1) == 1) ? waddr : 3'($urandom_range(0, 7));
         re_b = 1'($urandom_range(0, 1));
         raddr_b = ($urandom_range(0, 1) == 1) ? waddr : 3'($urandom_range(0, 7));
         tick();
      end

      // Reset during an active read stream discards the pending result
      idle(); write(1, 77);
      re_a = 1; raddr_a = 1; tick(); tick();
      reset = 1; tick();
      check("rst_mid_rvalid", 32'(rvalid_a[1]), 0);
      check("rst_mid_rdata",  32'(rdata_a[1]), 0);
      reset = 0; re_a = 0; tick();
      check("rst_after_rvalid", 32'(rvalid_a[0]), 0);
      re_a = 1; raddr_a = 1; tick();
      check("rst_cleared_miss", 32'(rmiss_a[1]), 1);
      idle(); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
